// File: rtl/regfile_wr_decoder.sv
// Registered address-to-one-hot write-enable decoder for the register file.
// A clear sweep walks every address so the register file can zero itself.
module regfile_wr_decoder #(
    parameter int ADDR_W     = 5,     // 1..6
    parameter bit MASK_ZERO  = 1'b1,
    parameter bit AUTO_CLEAR = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      clear_req,
    output logic [(1 << ADDR_W)-1:0]  out,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      wr_dropped
);

    localparam int                NUM_OUT   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_OUT - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(0);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_auto_pend;
    logic              w_clear_start;

    // One-hot decode with optional masking of the hard-wired zero register.
    function automatic logic [NUM_OUT-1:0] decode(input logic [ADDR_W-1:0] a);
        logic [NUM_OUT-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        v[0] = v[0] & ~MASK_ZERO;
        return v;
    endfunction

    // An automatic clear behaves exactly like a clear request on the first edge after reset.
    assign w_clear_start = clear_req | r_auto_pend;

    // Decoder state machine with registered enables and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= ZERO_ADDR;
            r_auto_pend <= AUTO_CLEAR;
            out         <= '0;
            clear_busy  <= 1'b0;
            clear_done  <= 1'b0;
            wr_dropped  <= 1'b0;
        end else begin
            r_auto_pend <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    clear_done <= 1'b0;
                    if (w_clear_start) begin
                        // Clear wins; a coincident write is discarded, not deferred.
                        out        <= decode(ZERO_ADDR);
                        clear_busy <= 1'b1;
                        wr_dropped <= enable;
                        r_cnt      <= ONE_ADDR;
                        r_state    <= ST_SWEEP;
                    end else begin
                        out        <= enable ? decode(address) : '0;
                        clear_busy <= 1'b0;
                        wr_dropped <= 1'b0;
                        r_cnt      <= r_cnt;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_SWEEP: begin
                    out        <= decode(r_cnt);
                    clear_busy <= 1'b1;
                    wr_dropped <= enable;
                    r_cnt      <= r_cnt + ONE_ADDR;
                    if (r_cnt == LAST_ADDR) begin
                        clear_done <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        clear_done <= 1'b0;
                        r_state    <= ST_SWEEP;
                    end
                end
                default: begin
                    out        <= '0;
                    clear_busy <= 1'b0;
                    clear_done <= 1'b0;
                    wr_dropped <= 1'b0;
                    r_cnt      <= ZERO_ADDR;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
